// File: rtl/elm_pkg.sv
// Shared types and sizing helpers for the ELM output stage.
// Also supplies fallback widths for the ROM_bitwidth / dataWidth project macros.
`ifndef ROM_bitwidth
`define ROM_bitwidth 8
`endif
`ifndef dataWidth
`define dataWidth 16
`endif

package elm_pkg;

  localparam int DEF_NUM_HIDDEN = 128;
  localparam int DEF_NUM_CLASS  = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Full-precision score width: unsigned act (+1 sign bit) x signed beta, summed NUM_HIDDEN times.
  function automatic int acc_width(input int in_w, input int data_w, input int num_hidden);
    return in_w + data_w + 1 + $clog2(num_hidden);
  endfunction

endpackage

// File: rtl/beta_memory.sv
// Beta weight RAM: one write port, one synchronous read port, optional parameter preload.
// Latency: 1 cycle from raddr to rdata.
// Backpressure: none; a write is taken in any cycle we is high.
module beta_memory #(
    parameter int                      DEPTH  = 40,
    parameter int                      DATA_W = 16,
    parameter int                      AW     = $clog2(DEPTH),
    parameter logic [DEPTH*DATA_W-1:0] INIT   = '0
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef BETA_PRETRAINED_EN
    initial begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] = INIT[i*DATA_W +: DATA_W];
    end
`endif

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata <= mem_q[raddr];
    end

endmodule

// File: rtl/elm_output_layer.sv
// ELM output stage: latch activations, serial beta MAC per class, arg-max, one-cycle result strobe.
// Optional BETA_PRETRAINED_EN: beta memory preloaded, beta write port ignored.
`ifndef ROM_bitwidth
`define ROM_bitwidth 8
`endif
`ifndef dataWidth
`define dataWidth 16
`endif

module elm_output_layer
  import elm_pkg::*;
#(
  parameter  int NUM_HIDDEN = DEF_NUM_HIDDEN,
  parameter  int NUM_CLASS  = DEF_NUM_CLASS,
  parameter  int IN_W       = `ROM_bitwidth,
  parameter  int DATA_W     = `dataWidth,
  parameter  int LAYER_NO   = 2,
  localparam int ACC_W      = acc_width(IN_W, DATA_W, NUM_HIDDEN),
  localparam int CLS_W      = $clog2(NUM_CLASS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hidden_valid,
  input  logic [NUM_HIDDEN*IN_W-1:0] hidden_in,
  input  logic                       beta_valid,
  input  logic [DATA_W-1:0]          beta_value,
  input  logic [2*`dataWidth:0]      config_layer_num,
  input  logic                       err_clr,
  output logic                       busy,
  output logic                       out_valid,
  output logic [CLS_W-1:0]           class_idx,
  output logic signed [ACC_W-1:0]    class_score,
  output logic                       err
);

  localparam int N      = NUM_CLASS * NUM_HIDDEN;
  localparam int AW     = $clog2(N);
  localparam int HW     = $clog2(NUM_HIDDEN);
  localparam int PROD_W = IN_W + 1 + DATA_W;
  localparam int CFG_W  = 2 * `dataWidth + 1;
  localparam logic [CFG_W-1:0] LAYER_MATCH = CFG_W'(LAYER_NO);

  state_t state_q, state_d;
  logic [AW-1:0]     k_q, waddr_q;
  logic [HW-1:0]     h_q, rd_h_q, prod_h_q;
  logic [CLS_W-1:0]  c_q, rd_c_q, prod_c_q, acc_c_q, best_idx_q, class_idx_q;
  logic [IN_W-1:0]   act_bank_q [NUM_HIDDEN];
  logic [IN_W-1:0]   act_q;
  logic [DATA_W-1:0] beta_rdata;
  logic signed [PROD_W-1:0] act_ext, beta_ext, prod_q;
  logic signed [ACC_W-1:0]  prod_ext, acc_q, best_score_q, class_score_q;
  logic rd_vld_q, prod_vld_q, acc_vld_q, out_valid_q, err_q, err_d;
  logic idle, mac, last_k, sample, beta_we, beta_drop;

  assign idle   = (state_q == ST_IDLE);
  assign mac    = (state_q == ST_MAC);
  assign last_k = (k_q == AW'(N - 1));
  assign sample = idle && hidden_valid;

`ifdef BETA_PRETRAINED_EN
  assign beta_we   = 1'b0;
  assign beta_drop = 1'b0;
`else
  logic beta_match;
  assign beta_match = beta_valid && (config_layer_num == LAYER_MATCH);
  assign beta_we    = beta_match && idle && !hidden_valid;
  assign beta_drop  = beta_match && !beta_we;
`endif

  beta_memory #(
    .DEPTH  (N),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_beta_memory (
    .clk   (clk),
    .we    (beta_we),
    .waddr (waddr_q),
    .wdata (beta_value),
    .raddr (k_q),
    .rdata (beta_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (hidden_valid) state_d = ST_MAC;
      ST_MAC:   if (last_k) state_d = ST_DRAIN;
      ST_DRAIN: if (!rd_vld_q && !prod_vld_q && !acc_vld_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A set in the same cycle as a clear must win.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (beta_drop || (hidden_valid && !idle)) err_d = 1'b1;
  end

  assign act_ext  = {{(DATA_W + 1){1'b0}}, act_q};
  assign beta_ext = {{(IN_W + 1){beta_rdata[DATA_W-1]}}, beta_rdata};
  assign prod_ext = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};

  // Datapath: valid flags below qualify these, so no reset is needed.
  always_ff @(posedge clk) begin
    if (sample) begin
      for (int i = 0; i < NUM_HIDDEN; i++) act_bank_q[i] <= hidden_in[i*IN_W +: IN_W];
    end
    act_q    <= act_bank_q[h_q];
    rd_h_q   <= h_q;
    rd_c_q   <= c_q;
    prod_q   <= act_ext * beta_ext;
    prod_h_q <= rd_h_q;
    prod_c_q <= rd_c_q;
    if (prod_vld_q) begin
      acc_q   <= (prod_h_q == '0) ? prod_ext : acc_q + prod_ext;
      acc_c_q <= prod_c_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      h_q           <= '0;
      c_q           <= '0;
      waddr_q       <= '0;
      rd_vld_q      <= 1'b0;
      prod_vld_q    <= 1'b0;
      acc_vld_q     <= 1'b0;
      best_idx_q    <= '0;
      best_score_q  <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      out_valid_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (mac) begin
        k_q <= k_q + 1'b1;
        if (h_q == HW'(NUM_HIDDEN - 1)) begin
          h_q <= '0;
          c_q <= c_q + 1'b1;
        end else begin
          h_q <= h_q + 1'b1;
        end
      end else begin
        k_q <= '0;
        h_q <= '0;
        c_q <= '0;
      end
      if (beta_we) waddr_q <= (waddr_q == AW'(N - 1)) ? '0 : waddr_q + 1'b1;
      rd_vld_q   <= mac;
      prod_vld_q <= rd_vld_q;
      acc_vld_q  <= prod_vld_q && (prod_h_q == HW'(NUM_HIDDEN - 1));
      // Strictly-greater replacement keeps ties on the lowest class index.
      if (acc_vld_q && ((acc_c_q == '0) || (acc_q > best_score_q))) begin
        best_idx_q   <= acc_c_q;
        best_score_q <= acc_q;
      end
      out_valid_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        class_idx_q   <= best_idx_q;
        class_score_q <= best_score_q;
      end
    end
  end

  assign busy        = !idle;
  assign out_valid   = out_valid_q;
  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;
  assign err         = err_q;

endmodule

// File: tb/tb_elm_output_layer.sv
// Scoreboard bench for elm_output_layer: directed scenarios plus randomized runs vs a dot-product model.
`ifndef dataWidth
`define dataWidth 16
`endif

module tb_elm_output_layer;

  localparam int NH     = 4;
  localparam int NC     = 3;
  localparam int IN_W   = 8;
  localparam int DATA_W = 16;
  localparam int N      = NH * NC;
  localparam int LAT    = N + 5;
  localparam int ACC_W  = IN_W + DATA_W + 1 + $clog2(NH);
  localparam int CFG_W  = 2 * `dataWidth + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hidden_valid = 1'b0;
  logic beta_valid = 1'b0;
  logic err_clr = 1'b0;
  logic [NH*IN_W-1:0] hidden_in = '0;
  logic [DATA_W-1:0]  beta_value = '0;
  logic [CFG_W-1:0]   config_layer_num = '0;
  logic busy, out_valid, err;
  logic [1:0] class_idx;
  logic [ACC_W-1:0] class_score;

  elm_output_layer #(
    .NUM_HIDDEN (NH),
    .NUM_CLASS  (NC),
    .IN_W       (IN_W),
    .DATA_W     (DATA_W),
    .LAYER_NO   (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .hidden_valid     (hidden_valid),
    .hidden_in        (hidden_in),
    .beta_valid       (beta_valid),
    .beta_value       (beta_value),
    .config_layer_num (config_layer_num),
    .err_clr          (err_clr),
    .busy             (busy),
    .out_valid        (out_valid),
    .class_idx        (class_idx),
    .class_score      (class_score),
    .err              (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int     idx;
    longint score;
    int     edge_no;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mem_m[N];
  int   waddr_m = 0;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", longint'(out_valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("class_idx", longint'(class_idx), mon_e.idx);
        check("class_score", longint'($signed(class_score)), mon_e.score);
        if (mon_e.edge_no >= 0) check("strobe_edge", cyc, mon_e.edge_no);
      end
    end
  end

  // Reference: per-class dot product, arg-max with ties to the lowest class.
  task automatic predict(input int h[NH], output int idx, output longint score);
    longint s;
    idx = 0;
    score = 0;
    for (int c = 0; c < NC; c++) begin
      s = 0;
      for (int j = 0; j < NH; j++) s += longint'(h[j]) * longint'(mem_m[c*NH + j]);
      if (c == 0 || s > score) begin
        score = s;
        idx = c;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beta_wr(input int v, input bit match);
    beta_valid = 1'b1;
    beta_value = DATA_W'(v);
    config_layer_num = match ? CFG_W'(2) : CFG_W'(3);
    tick();
    beta_valid = 1'b0;
    if (match) begin
      mem_m[waddr_m] = v;
      waddr_m = (waddr_m == N - 1) ? 0 : waddr_m + 1;
    end
  endtask

  task automatic load(input int b[N]);
    for (int i = 0; i < N; i++) beta_wr(b[i], 1'b1);
  endtask

  task automatic run(input int h[NH], input bit exp_out, input bit chk_edge);
    exp_t e;
    int idx;
    longint sc;
    for (int i = 0; i < NH; i++) hidden_in[i*IN_W +: IN_W] = IN_W'(h[i]);
    hidden_valid = 1'b1;
    if (exp_out) begin
      predict(h, idx, sc);
      e.idx = idx;
      e.score = sc;
      e.edge_no = chk_edge ? cyc + 1 + LAT : -1;
      exp_q.push_back(e);
    end
    tick();
    hidden_valid = 1'b0;
  endtask

  task automatic wait_results(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check({name, "_result_in_time"}, exp_q.size(), 0);
    if (exp_q.size() != 0) exp_q.delete();
    tick();
  endtask

  task automatic clear_err(input string name);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check({name, "_err_cleared"}, err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hv[NH];
    int hv2[NH];
    int bv[N];
    logic signed [15:0] r;

    rst = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_class_idx", class_idx, 0);
    check("rst_class_score", class_score, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    tick();

    // Scenario 1: basic arg-max
    bv = '{1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 3};
    load(bv);
    hv = '{1, 2, 3, 4};
    run(hv, 1'b1, 1'b1);
    wait_results("s1");
    check("s1_idx", class_idx, 2);
    check("s1_score", longint'($signed(class_score)), 12);
    check("s1_busy_idle", busy, 0);

    // Scenario 4: overrun at relative edge 5
    run(hv, 1'b1, 1'b1);
    repeat (4) tick();
    hv2 = '{9, 9, 9, 9};
    for (int i = 0; i < NH; i++) hidden_in[i*IN_W +: IN_W] = IN_W'(hv2[i]);
    hidden_valid = 1'b1;
    tick();
    hidden_valid = 1'b0;
    check("s4_busy", busy, 1);
    check("s4_err_set", err, 1);
    wait_results("s4");
    check("s4_idx", class_idx, 2);
    check("s4_score", longint'($signed(class_score)), 12);
    check("s4_err_sticky", err, 1);
    clear_err("s4");

    // Scenario 5: reset at relative edge 8, then rerun on retained betas
    run(hv, 1'b0, 1'b0);
    repeat (7) tick();
    rst = 1'b0;
    #1;
    check("s5_busy_in_reset", busy, 0);
    check("s5_out_valid_in_reset", out_valid, 0);
    waddr_m = 0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (25) tick();
    run(hv, 1'b1, 1'b1);
    wait_results("s5");
    check("s5_idx", class_idx, 2);
    check("s5_score", longint'($signed(class_score)), 12);

    // Scenario 2: tie; a coincident beta write is dropped and its err set beats err_clr
    bv = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    load(bv);
    beta_valid = 1'b1;
    beta_value = 16'd77;
    config_layer_num = CFG_W'(2);
    err_clr = 1'b1;
    run(hv, 1'b1, 1'b1);
    beta_valid = 1'b0;
    err_clr = 1'b0;
    check("s2_err_set_wins", err, 1);
    wait_results("s2");
    check("s2_idx", class_idx, 0);
    check("s2_score", longint'($signed(class_score)), 4);
    clear_err("s2");

    // Scenario 3: negative scores
    for (int i = 0; i < N; i++) bv[i] = -1;
    load(bv);
    run(hv, 1'b1, 1'b1);
    wait_results("s3");
    check("s3_idx", class_idx, 0);
    check("s3_score", longint'($signed(class_score)), -10);

    // Scenario 6: 13 writes, the 13th wraps to address 0
    for (int i = 0; i < N; i++) begin
      r = 16'($urandom);
      bv[i] = (i == NH || i == 2 * NH) ? int'($urandom_range(0, 104)) - 100 : int'(r);
    end
    load(bv);
    beta_wr(5, 1'b1);
    hv = '{1, 0, 0, 0};
    run(hv, 1'b1, 1'b1);
    wait_results("s6");
    check("s6_idx", class_idx, 0);
    check("s6_score", longint'($signed(class_score)), 5);

    // Randomized runs with ignored and dropped beta writes mixed in
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < N; i++) begin
        r = 16'($urandom);
        bv[i] = int'(r);
      end
      load(bv);
      beta_wr(int'($urandom_range(0, 65535)), 1'b0);
      check("rnd_layer_mismatch_no_err", err, 0);
      for (int j = 0; j < NH; j++) hv[j] = int'($urandom_range(0, 255));
      run(hv, 1'b1, 1'b1);
      if (it % 2 == 1) begin
        repeat (2) tick();
        beta_valid = 1'b1;
        beta_value = DATA_W'($urandom);
        config_layer_num = CFG_W'(2);
        tick();
        beta_valid = 1'b0;
        check("rnd_busy_write_err", err, 1);
      end
      wait_results("rnd");
      if (it % 2 == 1) clear_err("rnd");
    end

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
